// File: rtl/mmu_pkg.sv
// Shared definitions for the 2x2 systolic MMU and its result collector.
package mmu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam int MMU_DATA_W    = 8;
  // Edges from the start sample to the first column-0 accumulator output.
  localparam int MMU_FIRST_LAT = 2;

endpackage

// File: rtl/result_row_buffer.sv
// ROWS x 2 result storage with independent per-column write ports and one row read port.
module result_row_buffer #(
  parameter int ROWS   = 2,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0_i,
  input  logic [IDX_W-1:0]  widx0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [IDX_W-1:0]  widx1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o
);

  logic [DATA_W-1:0] col0_q [ROWS];
  logic [DATA_W-1:0] col1_q [ROWS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        col0_q[i] <= '0;
        col1_q[i] <= '0;
      end
    end else begin
      if (we0_i) col0_q[widx0_i] <= wdata0_i;
      if (we1_i) col1_q[widx1_i] <= wdata1_i;
    end
  end

  assign rdata0_o = col0_q[ridx_i];
  assign rdata1_o = col1_q[ridx_i];

endmodule

// File: rtl/mmu_result_collector.sv
// De-skews the MMU's staggered column outputs into a row buffer and streams rows
// out over a valid/ready handshake.
module mmu_result_collector
  import mmu_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int DATA_W    = MMU_DATA_W,
  parameter int FIRST_LAT = MMU_FIRST_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   acc_in0,
  input  logic [DATA_W-1:0]   acc_in1,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [2*DATA_W-1:0] row_data,
  output logic                row_last,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CNT_W     = $clog2(ROWS + 1);
  localparam int LAT_W     = $clog2(FIRST_LAT + 1);
  // WAIT spans FIRST_LAT-1 edges so CAPTURE is live at edge FIRST_LAT.
  localparam int WAIT_LAST = (FIRST_LAT >= 2) ? FIRST_LAT - 2 : 0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [IDX_W-1:0] rd_q, rd_d;
  logic             done_q, done_d;
  logic             overrun_q, overrun_d;

  logic              we0, we1;
  logic              accept, is_last;
  logic [DATA_W-1:0] rdata0, rdata1;

  result_row_buffer #(
    .ROWS   (ROWS),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .we0_i    (we0),
    .widx0_i  (IDX_W'(k_q)),
    .wdata0_i (acc_in0),
    .we1_i    (we1),
    .widx1_i  (IDX_W'(k_q - 1'b1)),
    .wdata1_i (acc_in1),
    .ridx_i   (rd_q),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  assign is_last = (rd_q == IDX_W'(ROWS - 1));
  assign accept  = (state_q == DRAIN) && row_ready;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    lat_d     = lat_q;
    rd_d      = rd_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    we0       = 1'b0;
    we1       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (FIRST_LAT == 1) ? CAPTURE : WAIT;
          k_d     = '0;
          lat_d   = '0;
          rd_d    = '0;
        end
      end
      WAIT: begin
        overrun_d = start;
        if (lat_q == LAT_W'(WAIT_LAST)) state_d = CAPTURE;
        else                            lat_d   = lat_q + 1'b1;
      end
      CAPTURE: begin
        overrun_d = start;
        // Column 1 trails column 0 by one edge, so it writes the previous row.
        we0 = (k_q < CNT_W'(ROWS));
        we1 = (k_q != '0);
        if (k_q == CNT_W'(ROWS)) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        overrun_d = start;
        if (accept) begin
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rd_d    = '0;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      lat_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      lat_q     <= lat_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_valid = (state_q == DRAIN);
  assign row_data  = row_valid ? {rdata1, rdata0} : '0;
  assign row_last  = row_valid && is_last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mmu_result_collector.sv
// Directed bench for mmu_result_collector with ROWS=2, FIRST_LAT=2.
module tb_mmu_result_collector;

  logic        clk = 1'b0;
  logic        reset, start, row_ready;
  logic [7:0]  acc_in0, acc_in1;
  logic        row_valid, row_last, busy, done, overrun;
  logic [15:0] row_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_result_collector #(.ROWS(2), .DATA_W(8), .FIRST_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .acc_in0   (acc_in0),
    .acc_in1   (acc_in1),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_last  (row_last),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  typedef struct {
    logic [7:0]  c00, c01, c10, c11;
    logic [15:0] exp0, exp1;
    int          stall;
    int          ovr_edge;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Start at edge 0, column 0 rows at edges 2,3, column 1 rows at edges 3,4.
  task automatic capture(input logic [7:0] c00, c01, c10, c11, input int ovr_edge);
    start = 1'b1;
    tick();                                    // edge 0
    chk("busy_after_start", busy, 1);
    chk("ovr_e0", overrun, 0);
    start = (ovr_edge == 1);
    acc_in0 = 8'h00; acc_in1 = 8'h00;
    tick();                                    // edge 1
    chk("ovr_e1", overrun, (ovr_edge == 1));
    start = 1'b0;
    acc_in0 = c00;
    tick();                                    // edge 2
    chk("ovr_e2", overrun, 0);
    start = (ovr_edge == 3);
    acc_in0 = c10; acc_in1 = c01;
    tick();                                    // edge 3
    chk("ovr_e3", overrun, (ovr_edge == 3));
    chk("valid_in_capture", row_valid, 0);
    start = 1'b0;
    acc_in0 = 8'h00; acc_in1 = c11;
    tick();                                    // edge 4
    chk("ovr_e4", overrun, 0);
    acc_in1 = 8'h00;
    chk("valid_drain", row_valid, 1);
  endtask

  // Leaves the bench in the done cycle.
  task automatic drain(input logic [15:0] exp0, exp1, input int stall);
    logic [15:0] expv [2];
    int n, guard;
    expv[0] = exp0; expv[1] = exp1;
    row_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      chk("hold_valid", row_valid, 1);
      chk("hold_data", row_data, exp0);
      chk("hold_last", row_last, 0);
      tick();
    end
    row_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 2 && guard < 20) begin
      if (row_valid) begin
        chk("row_data", row_data, expv[n]);
        chk("row_last", row_last, (n == 1));
        chk("busy_drain", busy, 1);
        chk("done_early", done, 0);
        n++;
      end
      tick();
      guard++;
    end
    if (n < 2) begin
      errors++;
      $display("FAIL drain_timeout: got %0d rows expected 2", n);
    end
    chk("done_pulse", done, 1);
    chk("valid_after_last", row_valid, 0);
    chk("busy_after_last", busy, 0);
    row_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h11, 8'h12, 8'h21, 8'h22, 16'h1211, 16'h2221, 0, 0};
    vecs[1] = '{8'h11, 8'h12, 8'h21, 8'h22, 16'h1211, 16'h2221, 3, 0};
    vecs[2] = '{8'h11, 8'h12, 8'h21, 8'h22, 16'h1211, 16'h2221, 0, 3};
    vecs[3] = '{8'h05, 8'h0B, 8'h0B, 8'h19, 16'h0B05, 16'h190B, 0, 0};
    vecs[4] = '{8'hAA, 8'h55, 8'hFF, 8'h00, 16'h55AA, 16'h00FF, 1, 1};

    reset = 1'b1; start = 1'b0; row_ready = 1'b0;
    acc_in0 = 8'h00; acc_in1 = 8'h00;
    tick(); tick();
    chk("rst_valid", row_valid, 0);
    chk("rst_data", row_data, 0);
    chk("rst_last", row_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      capture(vecs[v].c00, vecs[v].c01, vecs[v].c10, vecs[v].c11, vecs[v].ovr_edge);
      drain(vecs[v].exp0, vecs[v].exp1, vecs[v].stall);
      tick();
      chk("done_once", done, 0);
      tick();
    end

    // Reset while row 0 is pending.
    capture(8'h31, 8'h32, 8'h41, 8'h42, 0);
    row_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", row_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_done", done, 0);
    end
    capture(8'h51, 8'h52, 8'h61, 8'h62, 0);
    drain(16'h5251, 16'h6261, 0);
    tick();

    // Back-to-back: second start in the done cycle.
    capture(8'h01, 8'h02, 8'h03, 8'h04, 0);
    drain(16'h0201, 16'h0403, 0);
    capture(8'h7E, 8'h80, 8'hC3, 8'h3C, 0);
    drain(16'h807E, 16'h3CC3, 0);
    tick();
    chk("b2b_done_once", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
